dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
- Parametrised, handshaked data-memory controller; next generation of the single-cycle word-only data memory.
- Sits between the MIPS load/store stage and an on-chip word-wide store array.
- Adds byte, halfword and word stores via byte lanes, and sign- or zero-extended loads.
- Also adds a programmable wait-state latency, misalignment and range error reporting, and a valid/ready request handshake.

Parameters:
- DEPTH_WORDS, 512: number of 32-bit words in the array; power of two, 16..4096.
- WAIT_CYCLES, 1: extra access cycles modelling SRAM latency; range 0..15.
- BIG_ENDIAN, 0: 0 = byte 0 is bits [7:0]; 1 = byte 0 is bits [31:24].

Ports:
- ref_clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid: misaligned, illegal size or out of range.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset, asynchronous, active-high: state=IDLE, wait counter=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 once reset deasserts.
  - Array contents are not cleared.
  - Reset mid-operation aborts the request; no write is committed unless the commit edge already occurred.
- States: IDLE, ACCESS, RESP.
- Acceptance: on an edge with req_valid && req_ready, latch we, size, unsigned, addr and wdata.
  - Requests while not ready are ignored (no queue). The requester must hold them.
- Error check at acceptance:
  - size==11, or
  - size==01 && addr[0], or
  - size==10 && addr[1:0]!=0, or
  - addr[31:2] >= DEPTH_WORDS.
- Error path: IDLE->RESP directly. resp_err=1, rdata=0, no array write.
- Normal path: IDLE->ACCESS with counter=WAIT_CYCLES.
  - Each ACCESS edge decrements the counter.
  - On the ACCESS edge where counter==0 (the commit edge):
    - stores write the selected byte lanes;
    - loads capture the word;
    - state->RESP.
- RESP lasts exactly one cycle: resp_valid=1, then ->IDLE. There is no response backpressure.
- Latency: accept at edge k gives resp_valid high in the cycle after edge k+WAIT_CYCLES+1. For errors it is the cycle after edge k.
- Throughput: one request per WAIT_CYCLES+3 cycles.
- Byte lane mask is derived from size and addr[1:0]:
  - byte: 1 lane;
  - half: lanes {0,1} or {2,3};
  - word: all lanes.
  - The store datum is replicated across lanes before masking.
- Load extraction: select the addressed byte or half (endianness per BIG_ENDIAN), then extend to 32 bits per req_unsigned. Word loads are passed through.
- Store followed by a load to the same address returns the new data; the commit precedes the next acceptance.
- resp_rdata and resp_err hold their values outside RESP, but are meaningful only with resp_valid.

Decomposition:
- Package dmem_pkg:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD);
  - state_t enum (IDLE, ACCESS, RESP);
  - function lane_mask(size, addr[1:0]);
  - function extend(word, size, addr[1:0], unsigned, big_endian).
- One sub-module, dmem_array: DEPTH_WORDS x 32 storage with 4-bit byte write enable and registered read; no reset. This keeps the array swappable for an SRAM macro.

Test Plan:
- WAIT_CYCLES=1, reset, store word 0x11223344 at 0x10, then load word at 0x10 -> resp_valid in cycle 3 after each accept; load returns 0x11223344, err=0.
- Store byte 0xAB at 0x12 (little-endian), then load word at 0x10 -> 0x11AB3344. Load byte signed at 0x12 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Store half 0x8001 at 0x16, then load half signed at 0x16 -> 0xFFFF8001; unsigned -> 0x00008001.
- Word load at 0x11, half load at 0x13, size=11, and address 0x800 with DEPTH_WORDS=512 -> each gives err=1 and rdata=0 one cycle after accept; a following load at 0x10 shows memory unchanged.
- WAIT_CYCLES=3: hold req_valid asserted continuously -> req_ready low for 5 cycles between accepts; back-to-back accepts are spaced 6 cycles apart.
- Assert reset one cycle after accepting a store to 0x20 (WAIT_CYCLES=3) -> outputs clear, state IDLE; a later load at 0x20 returns the prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and byte-lane helpers for the data-memory controller.
// Lane masks are in byte-address order; the top maps them to physical lanes.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_t;

   function automatic logic [3:0] lane_mask(input size_t size, input logic [1:0] off);
      logic [3:0] mask;
      case (size)
         SZ_BYTE: mask = 4'b0001 << off;
         SZ_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] word, input size_t size,
                                          input logic [1:0] off, input logic uns,
                                          input logic big_endian);
      logic [1:0]  lane;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      lane = big_endian ? (2'd3 - off) : off;
      b    = word[{lane, 3'b000} +: 8];
      h    = (off[1] ^ big_endian) ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
         SZ_HALF: res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
         SZ_WORD: res = word;
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage with per-byte write enables and a registered read port.
// Deliberately reset-free so it can be replaced by an SRAM macro.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 512,
   parameter int AW          = 9
) (
   input  logic          ref_clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem_r [DEPTH_WORDS];
   logic [31:0] rdata_r;

   // Byte-lane write and registered read of the addressed word
   always_ff @(posedge ref_clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      rdata_r <= mem_r[idx];
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked data-memory controller: byte/half/word stores via lane enables,
// extended loads, programmable wait states and error responses.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 512,
   parameter int WAIT_CYCLES = 1,
   parameter int BIG_ENDIAN  = 0
) (
   input  logic        ref_clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int         AW      = $clog2(DEPTH_WORDS);
   localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
   localparam logic [3:0] WAIT_L  = 4'(WAIT_CYCLES);
   localparam logic       BE_L    = (BIG_ENDIAN != 0);

   state_t        state_r, state_s;
   logic [3:0]    cnt_r;
   logic          we_r, uns_r;
   logic [1:0]    size_r;
   logic [AW+1:0] addr_r;
   logic [31:0]   wdata_r;
   logic          ready_r, busy_r, resp_valid_r, resp_err_r;
   logic [31:0]   resp_rdata_r;

   logic          accept_s, err_s, size_err_s, commit_s;
   logic [3:0]    mask_a_s, mask_p_s, arr_we_s;
   logic [AW-1:0] arr_idx_s;
   logic [31:0]   arr_wdata_s, arr_rdata_s;

   // Request decode, error detection and next-state selection
   always_comb begin
      state_s     = state_r;
      accept_s    = 1'b0;
      commit_s    = 1'b0;
      size_err_s  = 1'b0;
      err_s       = 1'b0;
      case (req_size)
         2'b00:   size_err_s = 1'b0;
         2'b01:   size_err_s = req_addr[0];
         2'b10:   size_err_s = (req_addr[1:0] != 2'b00);
         default: size_err_s = 1'b1;
      endcase
      err_s = size_err_s | (req_addr[31:2] >= DEPTH_L);
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               accept_s = 1'b1;
               state_s  = err_s ? RESP : ACCESS;
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            if (cnt_r == 4'd0) begin
               commit_s = 1'b1;
               state_s  = RESP;
            end else begin
               state_s = ACCESS;
            end
         end
         RESP:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Array port: read ahead from the incoming address while idle so the word is ready at commit
   always_comb begin
      mask_a_s  = lane_mask(size_t'(size_r), addr_r[1:0]);
      mask_p_s  = BE_L ? {mask_a_s[0], mask_a_s[1], mask_a_s[2], mask_a_s[3]} : mask_a_s;
      arr_we_s  = (commit_s && we_r) ? mask_p_s : 4'b0000;
      arr_idx_s = (state_r == IDLE) ? req_addr[AW+1:2] : addr_r[AW+1:2];
      case (size_r)
         2'b00:   arr_wdata_s = {4{wdata_r[7:0]}};
         2'b01:   arr_wdata_s = {2{wdata_r[15:0]}};
         default: arr_wdata_s = wdata_r;
      endcase
   end

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_array (
      .ref_clk(ref_clk),
      .we     (arr_we_s),
      .idx    (arr_idx_s),
      .wdata  (arr_wdata_s),
      .rdata  (arr_rdata_s)
   );

   // State, request latches, wait counter and registered response outputs
   always_ff @(posedge ref_clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         cnt_r        <= 4'd0;
         we_r         <= 1'b0;
         uns_r        <= 1'b0;
         size_r       <= 2'b00;
         addr_r       <= '0;
         wdata_r      <= 32'h0000_0000;
         ready_r      <= 1'b1;
         busy_r       <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_err_r   <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
      end else begin
         state_r      <= state_s;
         ready_r      <= (state_s == IDLE);
         busy_r       <= (state_s != IDLE);
         resp_valid_r <= (state_s == RESP);
         if (accept_s) begin
            we_r    <= req_we;
            uns_r   <= req_unsigned;
            size_r  <= req_size;
            addr_r  <= req_addr[AW+1:0];
            wdata_r <= req_wdata;
            cnt_r   <= WAIT_L;
         end else if ((state_r == ACCESS) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
         end
         if (accept_s && err_s) begin
            resp_err_r   <= 1'b1;
            resp_rdata_r <= 32'h0000_0000;
         end else if (commit_s) begin
            resp_err_r   <= 1'b0;
            resp_rdata_r <= we_r ? 32'h0000_0000
                                 : extend(arr_rdata_s, size_t'(size_r), addr_r[1:0], uns_r, BE_L);
         end
      end
   end

   assign req_ready  = ready_r;
   assign busy       = busy_r;
   assign resp_valid = resp_valid_r;
   assign resp_err   = resp_err_r;
   assign resp_rdata = resp_rdata_r;

endmodule
